dma_burst_sequencer: RTL and testbench
======================================

// Module: dma_burst_sequencer
// PURPOSE
//  Sits directly downstream of the CSR manager.
//  - Takes one DMA command (source address, destination address, line count, mode) and splits it into burst requests.
//  - Bursts are at most MAX_BURST_CNT lines and never cross a 4KB page.
//  - Flow control: at most MAX_REQS_IN_FLIGHT bursts outstanding, tracked by credits.
//  - Reports busy/done/abort/error status back to the CSR manager.
// PARAMETERS
//  ADDR_W              64  byte-address width of src/dst addresses
//  LEN_W               32  width of command line count
//  MAX_BURST_CNT        8  max lines per burst (power of 2, 1..64)
//  MAX_REQS_IN_FLIGHT  32  max bursts issued but not yet completed
// PORTS
//  clk            in   1          single clock
//  reset          in   1          asynchronous, active-high reset
//  cmd_valid      in   1          new command offered
//  cmd_ready      out  1          high only in IDLE
//  cmd_src_addr   in   ADDR_W     source byte address; bits [5:0] ignored (64B lines)
//  cmd_dst_addr   in   ADDR_W     destination byte address; bits [5:0] ignored
//  cmd_num_lines  in   LEN_W      lines to move; 0 = no-op
//  cmd_mode       in   2          copied unchanged to every burst
//  abort          in   1          level, from CSR reset_engine
//  brst_valid     out  1          burst request valid
//  brst_ready     in   1          downstream engine accepts burst
//  brst_src_addr  out  ADDR_W     burst source byte address, [5:0]=0
//  brst_dst_addr  out  ADDR_W     burst destination byte address, [5:0]=0
//  brst_lines     out  $clog2(MAX_BURST_CNT)+1   lines in burst, 1..MAX_BURST_CNT
//  brst_mode      out  2          mode of owning command
//  brst_done      in   1          pulse: one outstanding burst completed
//  busy           out  1          state != IDLE
//  done           out  1          sticky; cleared on next cmd accept
//  aborted        out  1          sticky; cleared on next cmd accept
//  err_underflow  out  1          sticky; cleared only by reset
//  lines_issued   out  LEN_W      lines accepted downstream for current command
// BEHAVIOUR
//  Reset values: all outputs 0; cmd_ready=1; state IDLE; outstanding=0.
//  States:
//  - IDLE: cmd_valid&&cmd_ready latches the command.
//    - num_lines==0 -> DONE next cycle.
//    - Otherwise -> RUN; clears done, aborted and lines_issued.
//  - RUN: presents bursts until remaining==0, then -> DRAIN.
//  - DRAIN: waits for outstanding==0 -> DONE.
//  - DONE: sets done=1 for one cycle of transition, -> IDLE (done stays sticky).
//  Burst size: brst_lines = min(remaining, MAX_BURST_CNT, 64 - src_addr[11:6], 64 - dst_addr[11:6]).
//  - The 4KB page limit applies to both addresses.
//  Burst outputs are registered; the next burst is computed in the cycle after a handshake.
//  - brst_valid stays low for that cycle, so at most one burst per 2 cycles.
//  brst_valid asserts only in RUN with outstanding < MAX_REQS_IN_FLIGHT.
//  Once asserted, payload is held stable until brst_ready (AXI-style; no retraction).
//  On handshake:
//  - Both addresses advance by brst_lines*64 and wrap modulo 2^ADDR_W.
//  - remaining -= brst_lines; lines_issued += brst_lines.
//  Credits:
//  - outstanding increments on handshake and decrements on brst_done.
//  - Both in the same cycle -> unchanged.
//  - brst_done with outstanding==0 -> ignored; sets err_underflow.
//  abort=1 while in RUN or DRAIN:
//  - Drop brst_valid only if no burst is pending handshake; otherwise finish that handshake first.
//  - Go to DRAIN, wait for outstanding==0, set aborted=1 (not done), -> IDLE.
//  - abort in IDLE: cmd_ready=0 while abort is high.
//  Async reset mid-operation: immediate return to IDLE; in-flight bursts are forgotten, and later brst_done pulses raise err_underflow.
// TESTING
//  1. Command src=0x1000, dst=0x2000, lines=20, MAX_BURST_CNT=8, ready=1 -> bursts 8,8,4.
//     src 0x1000/0x1200/0x1400; done=1; lines_issued=20.
//  2. src=0x0FC0, dst=0x5000, lines=8 -> bursts 1 (0x0FC0), then 7 (0x1000); the page split is taken from src.
//  3. MAX_REQS_IN_FLIGHT=2, lines=64, no brst_done -> exactly 2 bursts, then brst_valid=0.
//     One brst_done -> third burst; outstanding never exceeds 2.
//  4. Handshake and brst_done in the same cycle at outstanding=1 -> outstanding stays 1.
//     A brst_done at outstanding=0 -> err_underflow=1.
//  5. lines=40; abort after 2 bursts with 2 outstanding -> no further bursts.
//     After 2 brst_done: aborted=1, done=0, busy=0, lines_issued=16.
//  6. Assert reset mid-RUN -> outputs return to reset values asynchronously.
//     A new lines=3 command then completes with a single burst of 3.

Source files
------------

// File: rtl/dma_burst_sequencer.sv
// dma_burst_sequencer: splits a DMA command into page-safe, credit-limited burst requests
module dma_burst_sequencer #(
  parameter int ADDR_W             = 64,
  parameter int LEN_W              = 32,
  parameter int MAX_BURST_CNT      = 8,
  parameter int MAX_REQS_IN_FLIGHT = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [ADDR_W-1:0]                cmd_src_addr,
  input  logic [ADDR_W-1:0]                cmd_dst_addr,
  input  logic [LEN_W-1:0]                 cmd_num_lines,
  input  logic [1:0]                       cmd_mode,
  input  logic                             abort,
  output logic                             brst_valid,
  input  logic                             brst_ready,
  output logic [ADDR_W-1:0]                brst_src_addr,
  output logic [ADDR_W-1:0]                brst_dst_addr,
  output logic [$clog2(MAX_BURST_CNT):0]   brst_lines,
  output logic [1:0]                       brst_mode,
  input  logic                             brst_done,
  output logic                             busy,
  output logic                             done,
  output logic                             aborted,
  output logic                             err_underflow,
  output logic [LEN_W-1:0]                 lines_issued
);
  localparam int BL_W = $clog2(MAX_BURST_CNT) + 1;
  localparam int OW   = $clog2(MAX_REQS_IN_FLIGHT + 1);
  localparam int LW   = ADDR_W - 6;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;
  state_t          state, state_nxt;
  logic [LW-1:0]   src_line, dst_line;
  logic [LEN_W-1:0] remaining;
  logic [1:0]      mode;
  logic [OW-1:0]   outstanding;
  logic            aborting, abort_seen, hs, accept, launch, drained, dn_ok;
  logic [6:0]      src_room, dst_room, pg, cap;
  logic [BL_W-1:0] blen;
  logic            unused;
  assign unused        = ^{cmd_src_addr[5:0], cmd_dst_addr[5:0]};
  assign brst_src_addr = {src_line, 6'b0};
  assign brst_dst_addr = {dst_line, 6'b0};
  assign hs            = brst_valid && brst_ready;
  assign accept        = cmd_valid && cmd_ready;
  assign abort_seen    = aborting || abort;
  assign drained       = state == S_DRAIN && outstanding == '0;
  assign dn_ok         = brst_done && outstanding != '0;
  assign launch        = state == S_RUN && !brst_valid && remaining != '0 && !abort &&
                         outstanding < OW'(MAX_REQS_IN_FLIGHT);
  // a burst may not cross a 4KB page on either side
  assign src_room      = 7'd64 - {1'b0, src_line[5:0]};
  assign dst_room      = 7'd64 - {1'b0, dst_line[5:0]};
  assign pg            = src_room < dst_room ? src_room : dst_room;
  assign cap           = pg < 7'(MAX_BURST_CNT) ? pg : 7'(MAX_BURST_CNT);
  assign blen          = remaining < LEN_W'(cap) ? BL_W'(remaining) : BL_W'(cap);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = cmd_num_lines == '0 ? S_FIN : S_RUN;
      S_RUN:   if ((remaining == '0 || abort) && !brst_valid) state_nxt = S_DRAIN;
      S_DRAIN: if (outstanding == '0) state_nxt = abort_seen ? S_IDLE : S_FIN;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    cmd_ready = state == S_IDLE && !abort;
    busy      = state != S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_line     <= '0;
      dst_line     <= '0;
      remaining    <= '0;
      mode         <= '0;
      brst_valid   <= 1'b0;
      brst_lines   <= '0;
      brst_mode    <= '0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      aborting     <= 1'b0;
      lines_issued <= '0;
    end else begin
      if (accept) begin
        src_line     <= cmd_src_addr[ADDR_W-1:6];
        dst_line     <= cmd_dst_addr[ADDR_W-1:6];
        remaining    <= cmd_num_lines;
        mode         <= cmd_mode;
        done         <= 1'b0;
        aborted      <= 1'b0;
        aborting     <= 1'b0;
        lines_issued <= '0;
      end else if (launch) begin
        brst_valid <= 1'b1;
        brst_lines <= blen;
        brst_mode  <= mode;
      end else if (hs) begin
        brst_valid   <= 1'b0;
        src_line     <= src_line + LW'(brst_lines);
        dst_line     <= dst_line + LW'(brst_lines);
        remaining    <= remaining - LEN_W'(brst_lines);
        lines_issued <= lines_issued + LEN_W'(brst_lines);
      end
      if (state == S_FIN) done <= 1'b1;
      if (drained && abort_seen) aborted <= 1'b1;
      if ((state == S_RUN || state == S_DRAIN) && abort) aborting <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      outstanding <= outstanding + OW'(hs) - OW'(dn_ok);
      if (brst_done && outstanding == '0) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_dma_burst_sequencer.sv
// tb_dma_burst_sequencer: directed command table plus hand-written credit, abort and reset sequences
module tb_dma_burst_sequencer;
  localparam int AW = 64, LW = 32, MB = 8, MR = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 0, cmd_ready, abort = 0, brst_valid, brst_ready = 0, brst_done = 0;
  logic busy, done, aborted, err_underflow;
  logic [AW-1:0] cmd_src_addr = 0, cmd_dst_addr = 0, brst_src_addr, brst_dst_addr;
  logic [LW-1:0] cmd_num_lines = 0, lines_issued;
  logic [1:0] cmd_mode = 0, brst_mode;
  logic [3:0] brst_lines;
  dma_burst_sequencer #(.ADDR_W(AW), .LEN_W(LW), .MAX_BURST_CNT(MB), .MAX_REQS_IN_FLIGHT(MR)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src_addr(cmd_src_addr), .cmd_dst_addr(cmd_dst_addr), .cmd_num_lines(cmd_num_lines),
    .cmd_mode(cmd_mode), .abort(abort), .brst_valid(brst_valid), .brst_ready(brst_ready),
    .brst_src_addr(brst_src_addr), .brst_dst_addr(brst_dst_addr), .brst_lines(brst_lines),
    .brst_mode(brst_mode), .brst_done(brst_done), .busy(busy), .done(done), .aborted(aborted),
    .err_underflow(err_underflow), .lines_issued(lines_issued));
  always #5 clk = ~clk;
  typedef struct {logic [63:0] src, dst; logic [31:0] lines; logic [1:0] mode; int nb, first;} cmd_t;
  typedef struct {logic [63:0] src, dst, len;} exp_t;
  typedef struct {logic [63:0] src, dst, len; logic [1:0] mode;} burst_t;
  cmd_t cv[5];
  exp_t ev[9];
  burst_t seen[$];
  int errors = 0, checks = 0, mo = 0, mo_max = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic cyc(input logic rdy, input logic dn);
    @(negedge clk);
    brst_ready = rdy;
    brst_done  = dn;
    #1;
    if (brst_valid && brst_ready)
      seen.push_back('{brst_src_addr, brst_dst_addr, 64'(brst_lines), brst_mode});
    mo = mo + ((brst_valid && brst_ready) ? 1 : 0) - ((dn && mo > 0) ? 1 : 0);
    if (mo > mo_max) mo_max = mo;
  endtask
  task automatic send(input logic [63:0] s, input logic [63:0] d, input logic [31:0] n, input logic [1:0] m);
    @(negedge clk);
    brst_done = 0;
    cmd_src_addr = s; cmd_dst_addr = d; cmd_num_lines = n; cmd_mode = m; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    seen.delete();
  endtask
  task automatic finish_cmd(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      cyc(1, mo > 0);
      if (!busy) break;
    end
    chk({name, " completes"}, 64'(i < budget), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    cv[0] = '{64'h1000, 64'h2000, 32'd20, 2'd0, 3, 0};
    ev[0] = '{64'h1000, 64'h2000, 64'd8};
    ev[1] = '{64'h1200, 64'h2200, 64'd8};
    ev[2] = '{64'h1400, 64'h2400, 64'd4};
    cv[1] = '{64'h0FC0, 64'h5000, 32'd8, 2'd1, 2, 3};
    ev[3] = '{64'h0FC0, 64'h5000, 64'd1};
    ev[4] = '{64'h1000, 64'h5040, 64'd7};
    cv[2] = '{64'h9000, 64'h9000, 32'd0, 2'd2, 0, 5};
    cv[3] = '{64'hA000, 64'hBF80, 32'd5, 2'd3, 2, 5};
    ev[5] = '{64'hA000, 64'hBF80, 64'd2};
    ev[6] = '{64'hA080, 64'hC000, 64'd3};
    cv[4] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 32'd2, 2'd1, 2, 7};
    ev[7] = '{64'hFFFF_FFFF_FFFF_FFC0, 64'h40, 64'd1};
    ev[8] = '{64'h0, 64'h80, 64'd1};
    #1;
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset busy", busy, 0);
    chk("reset brst_valid", brst_valid, 0);
    chk("reset done", done, 0);
    chk("reset err_underflow", err_underflow, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d cmd_ready", i), cmd_ready, 1);
      send(cv[i].src, cv[i].dst, cv[i].lines, cv[i].mode);
      finish_cmd($sformatf("v%0d", i), 200);
      chk($sformatf("v%0d bursts", i), 64'(seen.size()), 64'(cv[i].nb));
      for (int j = 0; j < cv[i].nb; j++) begin
        chk($sformatf("v%0d b%0d src", i, j), seen[j].src, ev[cv[i].first + j].src);
        chk($sformatf("v%0d b%0d dst", i, j), seen[j].dst, ev[cv[i].first + j].dst);
        chk($sformatf("v%0d b%0d len", i, j), seen[j].len, ev[cv[i].first + j].len);
        chk($sformatf("v%0d b%0d mode", i, j), 64'(seen[j].mode), 64'(cv[i].mode));
      end
      chk($sformatf("v%0d done", i), done, 1);
      chk($sformatf("v%0d aborted", i), aborted, 0);
      chk($sformatf("v%0d lines_issued", i), 64'(lines_issued), 64'(cv[i].lines));
    end
    chk("table in-flight bound", 64'(mo_max <= MR), 1);
    // credit stall: two bursts, then one per returned credit
    mo_max = 0;
    send(64'h10000, 64'h20000, 32'd64, 2'd0);
    repeat (20) cyc(1, 0);
    chk("stall bursts", 64'(seen.size()), 2);
    chk("stall brst_valid", brst_valid, 0);
    cyc(1, 1);
    repeat (10) cyc(1, 0);
    chk("one credit bursts", 64'(seen.size()), 3);
    chk("one credit brst_valid", brst_valid, 0);
    finish_cmd("credit", 300);
    chk("credit total bursts", 64'(seen.size()), 8);
    chk("credit lines_issued", 64'(lines_issued), 64);
    chk("credit max in flight", 64'(mo_max), 2);
    // handshake and completion coincide at one outstanding
    send(64'h30000, 64'h40000, 32'd24, 2'd1);
    for (int i = 0; i < 20 && seen.size() < 1; i++) cyc(1, 0);
    chk("coincide first burst", 64'(seen.size()), 1);
    for (int i = 0; i < 20 && !brst_valid; i++) cyc(0, 0);
    chk("coincide second valid", brst_valid, 1);
    cyc(1, 1);
    repeat (10) cyc(1, 0);
    chk("coincide third burst", 64'(seen.size()), 3);
    chk("coincide lines_issued", 64'(lines_issued), 24);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    chk("coincide still draining", busy, 1);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    chk("coincide idle", busy, 0);
    chk("coincide done", done, 1);
    chk("no underflow yet", err_underflow, 0);
    cyc(1, 1);
    cyc(1, 0);
    chk("underflow sticky", err_underflow, 1);
    // abort with two bursts in flight
    send(64'h50000, 64'h60000, 32'd40, 2'd2);
    repeat (20) cyc(1, 0);
    chk("abort pre bursts", 64'(seen.size()), 2);
    abort = 1;
    repeat (10) cyc(1, 0);
    chk("abort no new bursts", 64'(seen.size()), 2);
    chk("abort draining", busy, 1);
    cyc(1, 1);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    chk("abort aborted", aborted, 1);
    chk("abort done", done, 0);
    chk("abort busy", busy, 0);
    chk("abort lines_issued", 64'(lines_issued), 16);
    chk("abort blocks cmd_ready", cmd_ready, 0);
    abort = 0;
    #1;
    chk("cmd_ready after abort", cmd_ready, 1);
    // abort while a burst awaits its handshake
    send(64'h90000, 64'hA0000, 32'd16, 2'd3);
    for (int i = 0; i < 20 && !brst_valid; i++) cyc(0, 0);
    abort = 1;
    repeat (3) cyc(0, 0);
    chk("abort holds pending burst", brst_valid, 1);
    chk("abort holds payload", brst_src_addr, 64'h90000);
    cyc(1, 0);
    repeat (5) cyc(1, 0);
    chk("abort pending bursts", 64'(seen.size()), 1);
    cyc(1, 1);
    repeat (5) cyc(1, 0);
    chk("abort pending aborted", aborted, 1);
    chk("abort pending lines_issued", 64'(lines_issued), 8);
    abort = 0;
    // asynchronous reset in the middle of a run
    send(64'h70000, 64'h80000, 32'd64, 2'd3);
    repeat (3) cyc(1, 0);
    @(negedge clk);
    reset = 1;
    #1;
    chk("async busy", busy, 0);
    chk("async cmd_ready", cmd_ready, 1);
    chk("async brst_valid", brst_valid, 0);
    chk("async brst_lines", 64'(brst_lines), 0);
    chk("async lines_issued", 64'(lines_issued), 0);
    chk("async err_underflow", err_underflow, 0);
    @(negedge clk);
    reset = 0;
    mo = 0;
    cyc(1, 1);
    cyc(1, 0);
    chk("stale done underflow", err_underflow, 1);
    send(64'h7000, 64'h8000, 32'd3, 2'd0);
    finish_cmd("post reset", 100);
    chk("post reset bursts", 64'(seen.size()), 1);
    chk("post reset len", seen[0].len, 3);
    chk("post reset src", seen[0].src, 64'h7000);
    chk("post reset done", done, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
